// File: rtl/cnn_layer_pkg.sv
// Shared CNN layer-stage definitions.
// Purpose: common sizes and FSM state encoding for the pooled-map buffers.
// Contents: layer-2 pool buffer sizes (DATA_W/DEPTH/ADDR_W) and buffer FSM states.
package cnn_layer_pkg;

  localparam int unsigned POOL2_DATA_W = 8;
  localparam int unsigned POOL2_DEPTH  = 169;  // 13x13 pooled map
  localparam int unsigned POOL2_ADDR_W = 8;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_READY = 2'd1,
    ST_DRAIN = 2'd2
  } buf_state_e;

endpackage

// File: rtl/m_pool_ram_2.sv
// Simple dual-port RAM for the layer-2 pooled map.
// Ports:
//   clk                      - rising-edge clock
//   wr_en/wr_addr/wr_data    - synchronous write port
//   rd_en/rd_addr            - read request; rd_data updates the next cycle
//   rd_data                  - registered read data, held while rd_en is low
// Contents are not reset.
module m_pool_ram_2 #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 169,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rd_en) rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/m_pool_buffer_2.sv
// Layer-2 pooled-map buffer between the layer-2 pooling stage and layer 3.
// Fills DEPTH samples, then exposes them for random-access reads until the
// consumer signals done, then recycles.
// Ports:
//   clk, rst (sync, active-high)
//   d_in, data_available        - incoming pooled sample + one-cycle strobe
//   layer_2_ready               - upstream finished (level); early rise flags err_short
//   layer_3_rd_en/read_addr     - consumer read; d_out valid the next cycle
//   layer_3_done                - consumer finished pulse
//   d_out                       - registered read data (0 for out-of-range reads)
//   layer_3_begin               - buffer full, readable
//   write_count                 - samples stored in the current fill
//   err_overflow, err_short     - sticky error flags
module m_pool_buffer_2
  import cnn_layer_pkg::*;
#(
  parameter int unsigned DATA_W = POOL2_DATA_W,
  parameter int unsigned DEPTH  = POOL2_DEPTH,
  parameter int unsigned ADDR_W = POOL2_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] d_in,
  input  logic              data_available,
  input  logic              layer_2_ready,
  input  logic              layer_3_rd_en,
  input  logic [ADDR_W-1:0] layer_3_read_addr,
  input  logic              layer_3_done,
  output logic [DATA_W-1:0] d_out,
  output logic              layer_3_begin,
  output logic [ADDR_W-1:0] write_count,
  output logic              err_overflow,
  output logic              err_short
);

  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);

  buf_state_e        state_q, state_d;
  logic [ADDR_W-1:0] wcount_q, wcount_d;
  logic              ovf_q, ovf_d;
  logic              short_q, short_d;
  logic              l2r_q;
  logic              zero_q, zero_d;
  logic              ram_wr_en, ram_rd_en;
  logic [DATA_W-1:0] ram_rd_data;
  logic              l2r_rise;
  logic              rd_oor;

  assign l2r_rise = layer_2_ready & ~l2r_q;
  assign rd_oor   = (layer_3_read_addr >= DEPTH_A);

  always_comb begin
    state_d   = state_q;
    wcount_d  = wcount_q;
    ovf_d     = ovf_q;
    short_d   = short_q;
    zero_d    = zero_q;
    ram_wr_en = 1'b0;
    ram_rd_en = 1'b0;
    case (state_q)
      ST_FILL: begin
        // layer_3_done is not looked at here, so a final write always wins.
        if (data_available) begin
          ram_wr_en = 1'b1;
          wcount_d  = wcount_q + 1'b1;
          if (wcount_q == LAST_A) state_d = ST_READY;
        end
        if (l2r_rise && (wcount_q < DEPTH_A)) short_d = 1'b1;
      end
      ST_READY: begin
        if (data_available) ovf_d = 1'b1;
        // The RAM output register only loads on in-range reads; zero_q masks
        // it for out-of-range reads and after reset, so d_out holds otherwise.
        if (layer_3_rd_en) begin
          if (rd_oor) begin
            zero_d = 1'b1;
          end else begin
            ram_rd_en = 1'b1;
            zero_d    = 1'b0;
          end
        end
        if (layer_3_done) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (data_available) ovf_d = 1'b1;
        wcount_d = '0;
        state_d  = ST_FILL;
      end
      default: begin
        state_d  = ST_FILL;
        wcount_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_FILL;
      wcount_q <= '0;
      ovf_q    <= 1'b0;
      short_q  <= 1'b0;
      l2r_q    <= 1'b0;
      zero_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      wcount_q <= wcount_d;
      ovf_q    <= ovf_d;
      short_q  <= short_d;
      l2r_q    <= layer_2_ready;
      zero_q   <= zero_d;
    end
  end

  m_pool_ram_2 #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (ram_wr_en),
    .wr_addr (wcount_q),
    .wr_data (d_in),
    .rd_en   (ram_rd_en),
    .rd_addr (layer_3_read_addr),
    .rd_data (ram_rd_data)
  );

  assign d_out         = zero_q ? '0 : ram_rd_data;
  assign layer_3_begin = (state_q == ST_READY);
  assign write_count   = wcount_q;
  assign err_overflow  = ovf_q;
  assign err_short     = short_q;

endmodule
